single_cycle_cpu: RTL and testbench



---
 rtl/single_cycle_cpu_pkg.sv | 55 +++++
 rtl/single_cycle_cpu_reg_file.sv | 26 ++
 rtl/single_cycle_cpu.sv | 176 +++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/single_cycle_cpu_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core.
package single_cycle_cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMM
    } wb_sel_e;

    // alt selects sub/sra; callers decide when funct7 is meaningful.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/single_cycle_cpu_reg_file.sv
// 32 x XLEN register file: two combinational reads, one synchronous write, x0 hardwired to zero.
module reg_file
    import single_cycle_cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] register_memory [0:31] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != '0)) begin
            register_memory[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : register_memory[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : register_memory[raddr2_i];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle RV32I-subset core with internal word-addressed instruction and data memories.
module single_cycle_cpu
    import single_cycle_cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH     = 256,
    parameter int unsigned DMEM_DEPTH     = 256,
    parameter string       IMEM_INIT_FILE = ""
) (
    input logic clk,
    input logic rst
);

    localparam int unsigned IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int unsigned DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [XLEN-1:0] imem [IMEM_DEPTH] = '{
        0: 32'h0020_81B3,
        1: 32'h4041_82B3,
        2: 32'h4062_83B3,
        3: 32'h0320_8493,
        default: NOP_INSTR
    };
    logic [XLEN-1:0] dmem [DMEM_DEPTH] = '{default: '0};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [IAW-1:0]  imem_idx;
    logic [DAW-1:0]  dmem_idx;
    logic [XLEN-1:0] instr;

    assign imem_idx = IAW'({2'b00, pc_q[31:2]} % IMEM_DEPTH);
    assign instr    = imem[imem_idx];

    logic [6:0] opcode, funct7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    alu_op_e         alu_op;
    wb_sel_e         wb_sel;
    logic            use_imm, reg_write, mem_write, is_branch, is_jal;
    logic [XLEN-1:0] alu_imm;

    always_comb begin
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        use_imm   = 1'b0;
        alu_imm   = imm_i;
        reg_write = 1'b0;
        mem_write = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_op    = alu_decode(funct3, funct7 == F7_ALT);
                reg_write = 1'b1;
            end
            // Upper immediate bits only act as funct7 for the right-shift pair.
            OPC_OP_IMM: begin
                alu_op    = alu_decode(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
                use_imm   = 1'b1;
                reg_write = 1'b1;
            end
            OPC_LOAD: begin
                use_imm   = 1'b1;
                wb_sel    = WB_MEM;
                reg_write = 1'b1;
            end
            OPC_STORE: begin
                use_imm   = 1'b1;
                alu_imm   = imm_s;
                mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            end
            OPC_JAL: begin
                is_jal    = 1'b1;
                wb_sel    = WB_PC4;
                reg_write = 1'b1;
            end
            OPC_LUI: begin
                wb_sel    = WB_IMM;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] rs1_data, rs2_data, wb_data;

    reg_file reg_file_inst (
        .clk_i    (clk),
        .we_i     (reg_write && !rst),
        .waddr_i  (rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

    logic [XLEN-1:0] opb, alu_res;

    assign opb = use_imm ? alu_imm : rs2_data;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs1_data + opb;
            ALU_SUB:  alu_res = rs1_data - opb;
            ALU_AND:  alu_res = rs1_data & opb;
            ALU_OR:   alu_res = rs1_data | opb;
            ALU_XOR:  alu_res = rs1_data ^ opb;
            ALU_SLL:  alu_res = rs1_data << opb[4:0];
            ALU_SRL:  alu_res = rs1_data >> opb[4:0];
            ALU_SRA:  alu_res = $signed(rs1_data) >>> opb[4:0];
            ALU_SLT:  alu_res = {31'b0, $signed(rs1_data) < $signed(opb)};
            ALU_SLTU: alu_res = {31'b0, rs1_data < opb};
            default:  alu_res = '0;
        endcase
    end

    assign dmem_idx = DAW'({2'b00, alu_res[31:2]} % DMEM_DEPTH);

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = dmem[dmem_idx];
            WB_PC4:  wb_data = pc_q + 32'd4;
            WB_IMM:  wb_data = imm_u;
            default: wb_data = alu_res;
        endcase
    end

    logic taken;

    assign taken = is_branch && ((funct3 == F3_BEQ) ? (rs1_data == rs2_data)
                                                    : (rs1_data != rs2_data));

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (is_jal) begin
            pc_d = pc_q + imm_j;
        end else if (taken) begin
            pc_d = pc_q + imm_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_write) begin
            dmem[dmem_idx] <= rs2_data;
        end
    end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: per-instruction vector table plus hand-written program sequences.
module tb_single_cycle_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    single_cycle_cpu #(
        .IMEM_DEPTH     (256),
        .DMEM_DEPTH     (256),
        .IMEM_INIT_FILE ("")
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        string       name;
        int unsigned ridx;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_reg(input string name, input int unsigned ridx, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.ridx = ridx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, dut.reg_file_inst.register_memory[e.ridx], e.exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setreg(input int unsigned idx, input logic [31:0] val);
        dut.reg_file_inst.register_memory[idx] = val;
    endtask

    task automatic load_image(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        for (int i = 0; i < 256; i++) dut.imem[i] = NOP;
        dut.imem[0] = w0;
        dut.imem[1] = w1;
        dut.imem[2] = w2;
        dut.imem[3] = w3;
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        vec_t v;
        v.name  = name;
        v.instr = instr;
        v.a     = a;
        v.b     = b;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    initial begin
        // rd=x20, rs1=x21 (a), rs2=x22 (b); x20 starts at 0xDEAD
        add_vec("add",   enc_r(7'h00, 5'd22, 5'd21, 3'd0, 5'd20), 32'd7,        32'd5,        32'd12);
        add_vec("sub",   enc_r(7'h20, 5'd22, 5'd21, 3'd0, 5'd20), 32'd5,        32'd7,        32'hFFFF_FFFE);
        add_vec("and",   enc_r(7'h00, 5'd22, 5'd21, 3'd7, 5'd20), 32'hF0F0,     32'hFF00,     32'hF000);
        add_vec("or",    enc_r(7'h00, 5'd22, 5'd21, 3'd6, 5'd20), 32'hF0F0,     32'h0F00,     32'hFFF0);
        add_vec("xor",   enc_r(7'h00, 5'd22, 5'd21, 3'd4, 5'd20), 32'hFF,       32'h0F,       32'hF0);
        add_vec("sll",   enc_r(7'h00, 5'd22, 5'd21, 3'd1, 5'd20), 32'd1,        32'd35,       32'd8);
        add_vec("srl",   enc_r(7'h00, 5'd22, 5'd21, 3'd5, 5'd20), 32'h8000_0000, 32'd4,       32'h0800_0000);
        add_vec("sra",   enc_r(7'h20, 5'd22, 5'd21, 3'd5, 5'd20), 32'h8000_0000, 32'd4,       32'hF800_0000);
        add_vec("slt",   enc_r(7'h00, 5'd22, 5'd21, 3'd2, 5'd20), 32'hFFFF_FFFF, 32'd1,       32'd1);
        add_vec("sltu",  enc_r(7'h00, 5'd22, 5'd21, 3'd3, 5'd20), 32'hFFFF_FFFF, 32'd1,       32'd0);
        add_vec("addwrap", enc_r(7'h00, 5'd22, 5'd21, 3'd0, 5'd20), 32'hFFFF_FFFF, 32'd2,     32'd1);
        add_vec("addi",  enc_i(12'hFFF, 5'd21, 3'd0, 5'd20, 7'h13), 32'd0,      32'd0,        32'hFFFF_FFFF);
        add_vec("andi",  enc_i(12'h0F0, 5'd21, 3'd7, 5'd20, 7'h13), 32'hFF,     32'd0,        32'hF0);
        add_vec("ori",   enc_i(12'h001, 5'd21, 3'd6, 5'd20, 7'h13), 32'h100,    32'd0,        32'h101);
        add_vec("xori",  enc_i(12'hFFF, 5'd21, 3'd4, 5'd20, 7'h13), 32'hFF,     32'd0,        32'hFFFF_FF00);
        add_vec("slli",  enc_i(12'h004, 5'd21, 3'd1, 5'd20, 7'h13), 32'd3,      32'd0,        32'h30);
        add_vec("srli",  enc_i(12'h008, 5'd21, 3'd5, 5'd20, 7'h13), 32'hF000_0000, 32'd0,     32'h00F0_0000);
        add_vec("srai",  enc_i(12'h408, 5'd21, 3'd5, 5'd20, 7'h13), 32'hF000_0000, 32'd0,     32'hFFF0_0000);
        add_vec("slti",  enc_i(12'hFFD, 5'd21, 3'd2, 5'd20, 7'h13), 32'd5,      32'd0,        32'd0);
        add_vec("sltiu", enc_i(12'hFFF, 5'd21, 3'd3, 5'd20, 7'h13), 32'd5,      32'd0,        32'd1);
        add_vec("lui",   {20'h12345, 5'd20, 7'h37},                  32'd0,      32'd0,        32'h1234_5000);
        add_vec("badop", 32'h0000_0A7F,                              32'd1,      32'd2,        32'h0000_DEAD);

        // Default program: rst held from time 0
        #1;
        check("x3_powerup", dut.reg_file_inst.register_memory[3], 32'd0);
        setreg(1, 32'd10);
        setreg(4, 32'd5);
        setreg(6, 32'd4);
        step(2);
        check("pc_reset", dut.pc_q, 32'd0);
        rst = 1'b0;
        expect_reg("dflt_x3", 3, 32'd10);
        expect_reg("dflt_x5", 5, 32'd5);
        expect_reg("dflt_x7", 7, 32'd1);
        step(3);
        drain();
        check("dflt_pc3", dut.pc_q, 32'd12);
        expect_reg("dflt_x9", 9, 32'd60);
        expect_reg("dflt_x1", 1, 32'd10);
        expect_reg("dflt_x4", 4, 32'd5);
        expect_reg("dflt_x6", 6, 32'd4);
        step(1);
        drain();

        // Single-instruction vectors
        foreach (vecs[k]) begin
            rst = 1'b1;
            load_image(vecs[k].instr, NOP, NOP, NOP);
            setreg(20, 32'h0000_DEAD);
            setreg(21, vecs[k].a);
            setreg(22, vecs[k].b);
            step(1);
            rst = 1'b0;
            expect_reg(vecs[k].name, 20, vecs[k].exp);
            step(1);
            drain();
        end
        check("vec_pc", dut.pc_q, 32'd4);

        // x0 stays zero
        rst = 1'b1;
        load_image(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd10), NOP, NOP);
        setreg(10, 32'h55);
        step(1);
        rst = 1'b0;
        expect_reg("x0_zero", 0, 32'd0);
        expect_reg("x10_zero", 10, 32'd0);
        step(2);
        drain();

        // Store then load
        rst = 1'b1;
        load_image(enc_s(12'd8, 5'd1, 5'd0), enc_i(12'd8, 5'd0, 3'd2, 5'd11, 7'h03), NOP, NOP);
        setreg(1, 32'd10);
        setreg(11, 32'd0);
        step(1);
        rst = 1'b0;
        expect_reg("lw_x11", 11, 32'd10);
        step(2);
        drain();
        check("dmem_w2", dut.dmem[2], 32'd10);

        // Taken beq skips one instruction
        rst = 1'b1;
        load_image(enc_b(13'd8, 5'd0, 5'd0, 3'd0), enc_i(12'd1, 5'd0, 3'd0, 5'd12, 7'h13),
                   enc_i(12'd2, 5'd0, 3'd0, 5'd13, 7'h13), NOP);
        setreg(12, 32'd0);
        setreg(13, 32'd0);
        step(1);
        rst = 1'b0;
        expect_reg("beq_x12", 12, 32'd0);
        expect_reg("beq_x13", 13, 32'd2);
        step(2);
        drain();
        check("beq_pc", dut.pc_q, 32'd12);

        // Not-taken bne falls through
        rst = 1'b1;
        load_image(enc_b(13'd8, 5'd0, 5'd0, 3'd1), enc_i(12'd3, 5'd0, 3'd0, 5'd14, 7'h13), NOP, NOP);
        setreg(14, 32'd0);
        step(1);
        rst = 1'b0;
        expect_reg("bne_x14", 14, 32'd3);
        step(2);
        drain();
        check("bne_pc", dut.pc_q, 32'd8);

        // jal links PC+4
        rst = 1'b1;
        load_image(enc_j(21'd8, 5'd1), NOP, NOP, NOP);
        setreg(1, 32'd0);
        step(1);
        rst = 1'b0;
        expect_reg("jal_x1", 1, 32'd4);
        step(1);
        drain();
        check("jal_pc", dut.pc_q, 32'd8);

        // Reset mid-run: PC restarts, registers kept, writes inhibited during reset
        rst = 1'b1;
        load_image(enc_i(12'd7, 5'd0, 3'd0, 5'd15, 7'h13), enc_i(12'd1, 5'd15, 3'd0, 5'd16, 7'h13),
                   enc_i(12'd9, 5'd0, 3'd0, 5'd17, 7'h13), NOP);
        setreg(15, 32'd0);
        setreg(16, 32'd0);
        setreg(17, 32'd0);
        step(1);
        rst = 1'b0;
        step(2);
        check("mid_pc_run", dut.pc_q, 32'd8);
        rst = 1'b1;
        expect_reg("mid_x15", 15, 32'd7);
        expect_reg("mid_x16", 16, 32'd8);
        expect_reg("mid_x17_inhib", 17, 32'd0);
        step(1);
        drain();
        check("mid_pc_reset", dut.pc_q, 32'd0);
        rst = 1'b0;
        expect_reg("mid_x15_again", 15, 32'd7);
        step(1);
        drain();
        check("mid_pc_restart", dut.pc_q, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
